modulo_arbitro_mem_dados: RTL and testbench

- Two-requester arbiter and sequencer in front of the single-port-per-direction data memory.
- Requester A is the processor load/store unit. Requester B is the I/O / loader port.
- Grants at most one access (read or write) per cycle and drives the memory's write and read ports.
- Returns read data with a valid strobe to the requester that issued the read. Supports a bounded lock (burst ownership) so one requester can run back-to-back accesses.

---
 rtl/modulo_arbitro_mem_dados_pkg.sv | 13 +
 rtl/modulo_arbitro_mem_dados_rr2.sv | 32 +++
 rtl/modulo_arbitro_mem_dados.sv | 127 ++++++++++++
 tb/tb_modulo_arbitro_mem_dados.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/modulo_arbitro_mem_dados_pkg.sv
// Shared types for the data-memory arbiter: FSM state encoding and requester ids.
package modulo_arbitro_mem_dados_pkg;

    typedef enum logic [1:0] {
        LIVRE   = 2'd0,
        POSSE_A = 2'd1,
        POSSE_B = 2'd2
    } state_e;

    localparam logic ID_A = 1'b0;
    localparam logic ID_B = 1'b1;

endpackage : modulo_arbitro_mem_dados_pkg

// File: rtl/modulo_arbitro_mem_dados_rr2.sv
// Combinational two-way pick: round-robin on ties when free, owner-only while locked.
module modulo_arbitro_rr2
    import modulo_arbitro_mem_dados_pkg::*;
(
    input  logic   req_a,
    input  logic   req_b,
    input  logic   ultimo,
    input  state_e state,
    output logic   gnt_a,
    output logic   gnt_b
);

    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        case (state)
            LIVRE: begin
                if (req_a && req_b) begin
                    gnt_a = (ultimo == ID_B);
                    gnt_b = (ultimo == ID_A);
                end else begin
                    gnt_a = req_a;
                    gnt_b = req_b;
                end
            end
            POSSE_A: gnt_a = req_a;
            POSSE_B: gnt_b = req_b;
            default: ;
        endcase
    end

endmodule : modulo_arbitro_rr2

// File: rtl/modulo_arbitro_mem_dados.sv
// Two-requester arbiter/sequencer in front of the data memory, with bounded burst lock.
module modulo_arbitro_mem_dados
    import modulo_arbitro_mem_dados_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 13,
    parameter int unsigned MAX_LOCK   = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_a,
    input  logic                  we_a,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic [DATA_WIDTH-1:0] wdata_a,
    input  logic                  lock_a,
    output logic                  gnt_a,
    output logic                  rvalid_a,
    output logic [DATA_WIDTH-1:0] rdata_a,
    input  logic                  req_b,
    input  logic                  we_b,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    input  logic [DATA_WIDTH-1:0] wdata_b,
    input  logic                  lock_b,
    output logic                  gnt_b,
    output logic                  rvalid_b,
    output logic [DATA_WIDTH-1:0] rdata_b,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic [ADDR_WIDTH-1:0] mem_write_addr,
    output logic [ADDR_WIDTH-1:0] mem_read_addr,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_q
);

    localparam int unsigned CW      = $clog2(MAX_LOCK + 1);
    localparam bit          LOCK_EN = (MAX_LOCK > 1);

    state_e          state_q, state_d;
    logic            ultimo_q, ultimo_d;
    logic [CW-1:0]   cont_lock_q, cont_lock_d;
    logic [CW-1:0]   cont_dec;
    logic            rvalid_a_q, rvalid_a_d;
    logic            rvalid_b_q, rvalid_b_d;
    logic            gnt_a_rr, gnt_b_rr;
    logic            lock_sel;

    modulo_arbitro_rr2 u_rr2 (
        .req_a  (req_a),
        .req_b  (req_b),
        .ultimo (ultimo_q),
        .state  (state_q),
        .gnt_a  (gnt_a_rr),
        .gnt_b  (gnt_b_rr)
    );

    // Reset blocks any grant in the same cycle so memory is never written during reset.
    assign gnt_a = gnt_a_rr & ~reset;
    assign gnt_b = gnt_b_rr & ~reset;

    // Idle mux position is A; B only drives the memory when it holds the grant.
    assign mem_write_addr = gnt_b ? addr_b : addr_a;
    assign mem_read_addr  = gnt_b ? addr_b : addr_a;
    assign mem_data       = gnt_b ? wdata_b : wdata_a;
    assign mem_we         = (gnt_a & we_a) | (gnt_b & we_b);

    assign rdata_a  = mem_q;
    assign rdata_b  = mem_q;
    assign rvalid_a = rvalid_a_q & ~reset;
    assign rvalid_b = rvalid_b_q & ~reset;

    assign lock_sel = gnt_b ? lock_b : lock_a;
    assign cont_dec = cont_lock_q - CW'(1);

    always_comb begin
        state_d     = state_q;
        ultimo_d    = ultimo_q;
        cont_lock_d = cont_lock_q;
        rvalid_a_d  = gnt_a & ~we_a;
        rvalid_b_d  = gnt_b & ~we_b;
        case (state_q)
            LIVRE: begin
                if (gnt_a || gnt_b) begin
                    ultimo_d = gnt_b ? ID_B : ID_A;
                    if (lock_sel && LOCK_EN) begin
                        state_d     = gnt_b ? POSSE_B : POSSE_A;
                        cont_lock_d = CW'(MAX_LOCK - 1);
                    end
                end
            end
            POSSE_A: begin
                if (!req_a) begin
                    state_d = LIVRE;
                end else if (gnt_a) begin
                    ultimo_d    = ID_A;
                    cont_lock_d = cont_dec;
                    if (!lock_a || cont_dec == '0) state_d = LIVRE;
                end
            end
            POSSE_B: begin
                if (!req_b) begin
                    state_d = LIVRE;
                end else if (gnt_b) begin
                    ultimo_d    = ID_B;
                    cont_lock_d = cont_dec;
                    if (!lock_b || cont_dec == '0) state_d = LIVRE;
                end
            end
            default: state_d = LIVRE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= LIVRE;
            ultimo_q    <= ID_B;
            cont_lock_q <= '0;
            rvalid_a_q  <= 1'b0;
            rvalid_b_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ultimo_q    <= ultimo_d;
            cont_lock_q <= cont_lock_d;
            rvalid_a_q  <= rvalid_a_d;
            rvalid_b_q  <= rvalid_b_d;
        end
    end

endmodule : modulo_arbitro_mem_dados

// File: tb/tb_modulo_arbitro_mem_dados.sv
// Scoreboard bench: behavioural arbiter + memory model predicts grants and read returns.
module tb_modulo_arbitro_mem_dados;

    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 13;
    localparam int unsigned ML    = 8;
    localparam int unsigned DEPTH = 1 << AW;

    logic          clock = 1'b0;
    logic          reset;
    logic          req_a, we_a, lock_a, gnt_a, rvalid_a;
    logic [AW-1:0] addr_a;
    logic [DW-1:0] wdata_a, rdata_a;
    logic          req_b, we_b, lock_b, gnt_b, rvalid_b;
    logic [AW-1:0] addr_b;
    logic [DW-1:0] wdata_b, rdata_b;
    logic [DW-1:0] mem_data, mem_q;
    logic [AW-1:0] mem_write_addr, mem_read_addr;
    logic          mem_we;

    logic [DW-1:0] tb_mem    [DEPTH];
    logic [DW-1:0] model_mem [DEPTH];

    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } rd_t;
    rd_t qa[$];
    rd_t qb[$];

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int owner = 0;   // 0 free, 1 A holds lock, 2 B holds lock
    int taken = 0;   // transfers taken in the current lock tenure
    int last  = 1;   // 0 = A served last, 1 = B served last

    modulo_arbitro_mem_dados #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_LOCK(ML)) dut (
        .clock(clock), .reset(reset),
        .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a), .lock_a(lock_a),
        .gnt_a(gnt_a), .rvalid_a(rvalid_a), .rdata_a(rdata_a),
        .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b), .lock_b(lock_b),
        .gnt_b(gnt_b), .rvalid_b(rvalid_b), .rdata_b(rdata_b),
        .mem_data(mem_data), .mem_write_addr(mem_write_addr), .mem_read_addr(mem_read_addr),
        .mem_we(mem_we), .mem_q(mem_q)
    );

    always #5 clock = ~clock;

    // Data memory: registered read, 1-cycle latency.
    always @(posedge clock) begin
        logic [DW-1:0] rd;
        rd = tb_mem[mem_read_addr];
        if (mem_we) tb_mem[mem_write_addr] = mem_data;
        mem_q <= rd;
    end

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
        end
    endfunction

    // Reference model: evaluates the cycle's arbitration from the rules, then advances.
    always @(negedge clock) begin : model
        bit            ea, eb, ewe;
        logic [AW-1:0] eaddr;
        cyc++;
        ea = 1'b0;
        eb = 1'b0;
        if (reset) begin
            owner = 0; last = 1; taken = 0;
            qa.delete(); qb.delete();
        end else if (owner == 0) begin
            if (req_a && req_b) begin
                ea = (last == 1);
                eb = !ea;
            end else begin
                ea = req_a;
                eb = req_b;
            end
            if (ea || eb) begin
                last = eb ? 1 : 0;
                if ((eb ? lock_b : lock_a) && ML > 1) begin
                    owner = eb ? 2 : 1;
                    taken = 1;
                end
            end
        end else if (owner == 1) begin
            if (!req_a) owner = 0;
            else begin
                ea = 1'b1; last = 0; taken++;
                if (!lock_a || taken == ML) owner = 0;
            end
        end else begin
            if (!req_b) owner = 0;
            else begin
                eb = 1'b1; last = 1; taken++;
                if (!lock_b || taken == ML) owner = 0;
            end
        end
        ewe   = (ea && we_a) || (eb && we_b);
        eaddr = eb ? addr_b : addr_a;
        chk("gnt_a", gnt_a, ea);
        chk("gnt_b", gnt_b, eb);
        chk("mem_we", mem_we, ewe);
        chk("mem_write_addr", mem_write_addr, eaddr);
        chk("mem_read_addr", mem_read_addr, eaddr);
        if (ewe) begin
            chk("mem_data", mem_data, eb ? wdata_b : wdata_a);
            model_mem[eaddr] = eb ? wdata_b : wdata_a;
        end else if (ea) begin
            qa.push_back('{due: cyc + 1, data: model_mem[eaddr]});
        end else if (eb) begin
            qb.push_back('{due: cyc + 1, data: model_mem[eaddr]});
        end
    end

    // Monitor: read returns must appear exactly one cycle after acceptance.
    always @(negedge clock) begin
        #2;
        if (qa.size() > 0 && qa[0].due == cyc) begin
            chk("rvalid_a", rvalid_a, 1);
            chk("rdata_a", rdata_a, qa[0].data);
            qa.delete(0);
        end else chk("rvalid_a_idle", rvalid_a, 0);
        if (qb.size() > 0 && qb[0].due == cyc) begin
            chk("rvalid_b", rvalid_b, 1);
            chk("rdata_b", rdata_b, qb[0].data);
            qb.delete(0);
        end else chk("rvalid_b_idle", rvalid_b, 0);
    end

    task automatic set_a(logic r, logic w, logic [AW-1:0] a, logic [DW-1:0] d, logic l);
        req_a = r; we_a = w; addr_a = a; wdata_a = d; lock_a = l;
    endtask

    task automatic set_b(logic r, logic w, logic [AW-1:0] a, logic [DW-1:0] d, logic l);
        req_b = r; we_b = w; addr_b = a; wdata_b = d; lock_b = l;
    endtask

    task automatic tick(output bit ga, output bit gb);
        @(negedge clock);
        #1;
        ga = gnt_a;
        gb = gnt_b;
        @(posedge clock);
        #1;
    endtask

    task automatic idle(int n);
        bit ga, gb;
        set_a(0, 0, '0, '0, 0);
        set_b(0, 0, '0, '0, 0);
        for (int i = 0; i < n; i++) tick(ga, gb);
    endtask

    initial begin
        bit ga, gb, pa, pb;
        for (int i = 0; i < int'(DEPTH); i++) begin
            tb_mem[i]    = $urandom;
            model_mem[i] = tb_mem[i];
        end
        reset = 1'b1;
        set_a(0, 0, '0, '0, 0);
        set_b(0, 0, '0, '0, 0);
        tick(ga, gb); tick(ga, gb);
        reset = 1'b0;

        // A writes then reads back address 5
        set_a(1, 1, AW'(5), 32'hCAFE0001, 0); tick(ga, gb);
        set_a(1, 0, AW'(5), '0, 0);           tick(ga, gb);
        idle(1);

        // Both reading from reset: alternation A,B,A,B
        reset = 1'b1; tick(ga, gb); reset = 1'b0;
        set_a(1, 0, AW'(1), '0, 0);
        set_b(1, 0, AW'(2), '0, 0);
        for (int i = 0; i < 4; i++) tick(ga, gb);
        idle(1);

        // B takes a lock alone, A then contends: 8 B transfers then A
        set_b(1, 0, AW'(7), '0, 1); tick(ga, gb);
        set_a(1, 0, AW'(6), '0, 0);
        for (int i = 0; i < 9; i++) tick(ga, gb);
        idle(1);

        // A locks, then releases voluntarily while B waits
        set_a(1, 0, AW'(3), '0, 1); tick(ga, gb);
        set_a(0, 0, '0, '0, 0);
        set_b(1, 0, AW'(4), '0, 0); tick(ga, gb);
        tick(ga, gb);
        idle(1);

        // Reset right after an accepted read drops it; next tie goes to A
        set_a(1, 0, AW'(9), '0, 0); tick(ga, gb);
        reset = 1'b1; set_a(0, 0, '0, '0, 0); tick(ga, gb);
        reset = 1'b0;
        set_a(1, 0, AW'(10), '0, 0);
        set_b(1, 0, AW'(11), '0, 0); tick(ga, gb);
        idle(2);

        // B at the top address, then A reads address 0
        set_b(1, 1, AW'(13'h1FFF), 32'hFFFFFFFF, 0); tick(ga, gb);
        set_b(1, 0, AW'(13'h1FFF), '0, 0);           tick(ga, gb);
        set_b(0, 0, '0, '0, 0);
        set_a(1, 0, AW'(0), '0, 0);                  tick(ga, gb);
        idle(2);

        // Random traffic: each side holds its request until granted
        pa = 0; pb = 0;
        for (int i = 0; i < 2000; i++) begin
            reset = ($urandom_range(0, 199) == 0);
            if (!pa) begin
                if ($urandom_range(0, 3) != 0) begin
                    pa = 1;
                    set_a(1, 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 7) == 0) ? AW'($urandom_range(0, DEPTH - 1))
                                                      : AW'($urandom_range(0, 15)),
                          $urandom, 1'($urandom_range(0, 1)));
                end else set_a(0, 0, '0, '0, 0);
            end
            if (!pb) begin
                if ($urandom_range(0, 3) != 0) begin
                    pb = 1;
                    set_b(1, 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 7) == 0) ? AW'($urandom_range(0, DEPTH - 1))
                                                      : AW'($urandom_range(0, 15)),
                          $urandom, 1'($urandom_range(0, 1)));
                end else set_b(0, 0, '0, '0, 0);
            end
            tick(ga, gb);
            if (ga) pa = 0;
            if (gb) pb = 0;
        end
        reset = 1'b0;
        idle(4);
        chk("drain_a", 64'(qa.size()), 0);
        chk("drain_b", 64'(qb.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_modulo_arbitro_mem_dados
